// File: rtl/id_ex_issue_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_issue_reg_if
//  Shared types and the port bundle for the 3-way ID/EX issue register.
//
//  id_ex_issue_reg_pkg
//   ID_EX_PACKET   packed packet carried from ID into EX
//   BUBBLE         the canonical empty packet (valid=0, inst=NOP, dest=ZERO_REG,
//                  both operand selects = RS_IS_RS, everything else 0)
//
//  id_ex_issue_reg_if signals (master = upstream/driver, slave = the register)
//   enable              1 = stage advances, 0 = hold
//   squash              EX mispredict flush
//   rollback [1:0]      number of youngest ways to squash (0..3)
//   id_packet_in_0..2   packets from detection_unit, way 0 oldest
//   ex_packet_0..2      registered packets to EX
//   redirect_valid      fetch must restart at redirect_pc (combinational)
//   redirect_pc         PC of the oldest squashed way
//   rb_streak [2:0]     consecutive accepted-rollback cycles, saturating
//   stat_rb_cycles/stat_rb_insts  only when ROLLBACK_STATS_EN is defined
// ---------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h00000013
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package id_ex_issue_reg_pkg;

   localparam int XLEN = `XLEN;

   typedef enum logic [1:0] {
      RS_IS_IMM = 2'd0,
      RS_IS_RS  = 2'd1,
      RS_IS_PC  = 2'd2
   } rs_select_e;

   typedef struct packed {
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] NPC;
      logic [31:0]     inst;
      logic [4:0]      dest_reg_idx;
      rs_select_e      rs1_select;
      rs_select_e      rs2_select;
      logic            rd_mem;
      logic            wr_mem;
      logic            halt;
      logic            illegal;
      logic            valid;
   } ID_EX_PACKET;

   localparam ID_EX_PACKET BUBBLE = '{
      PC:           '0,
      NPC:          '0,
      inst:         `NOP,
      dest_reg_idx: `ZERO_REG,
      rs1_select:   RS_IS_RS,
      rs2_select:   RS_IS_RS,
      rd_mem:       1'b0,
      wr_mem:       1'b0,
      halt:         1'b0,
      illegal:      1'b0,
      valid:        1'b0
   };

endpackage

interface id_ex_issue_reg_if;
   import id_ex_issue_reg_pkg::*;

   logic            enable;
   logic            squash;
   logic [1:0]      rollback;
   ID_EX_PACKET     id_packet_in_0;
   ID_EX_PACKET     id_packet_in_1;
   ID_EX_PACKET     id_packet_in_2;
   ID_EX_PACKET     ex_packet_0;
   ID_EX_PACKET     ex_packet_1;
   ID_EX_PACKET     ex_packet_2;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic [2:0]      rb_streak;
`ifdef ROLLBACK_STATS_EN
   logic [31:0]     stat_rb_cycles;
   logic [31:0]     stat_rb_insts;
`endif

`ifdef ROLLBACK_STATS_EN
   modport master (
      output enable, squash, rollback, id_packet_in_0, id_packet_in_1, id_packet_in_2,
      input  ex_packet_0, ex_packet_1, ex_packet_2, redirect_valid, redirect_pc, rb_streak,
      input  stat_rb_cycles, stat_rb_insts
   );
   modport slave (
      input  enable, squash, rollback, id_packet_in_0, id_packet_in_1, id_packet_in_2,
      output ex_packet_0, ex_packet_1, ex_packet_2, redirect_valid, redirect_pc, rb_streak,
      output stat_rb_cycles, stat_rb_insts
   );
`else
   modport master (
      output enable, squash, rollback, id_packet_in_0, id_packet_in_1, id_packet_in_2,
      input  ex_packet_0, ex_packet_1, ex_packet_2, redirect_valid, redirect_pc, rb_streak
   );
   modport slave (
      input  enable, squash, rollback, id_packet_in_0, id_packet_in_1, id_packet_in_2,
      output ex_packet_0, ex_packet_1, ex_packet_2, redirect_valid, redirect_pc, rb_streak
   );
`endif

endinterface

// File: rtl/id_ex_issue_reg.sv
// ---------------------------------------------------------------------------
// id_ex_issue_reg
//  3-way ID/EX pipeline register. Latches the packets forwarded by the
//  detection unit, turns the youngest `rollback` ways into bubbles and, in the
//  same cycle, points fetch at the PC of the oldest squashed way.
//
//  Ports
//   clock   rising-edge clock
//   reset   asynchronous, active-high
//   bus     id_ex_issue_reg_if.slave (enable, squash, rollback, packets in/out,
//           redirect_valid, redirect_pc, rb_streak)
//
//  Parameters
//   WAYS        issue width, only 3 is supported
//   RB_SAT_MAX  saturation value of rb_streak
//
//  Optional feature macro: ROLLBACK_STATS_EN adds stat_rb_cycles and
//  stat_rb_insts rollback counters.
// ---------------------------------------------------------------------------

module id_ex_issue_reg #(
   parameter int         WAYS       = 3,
   parameter logic [2:0] RB_SAT_MAX = 3'd7
) (
   input logic              clock,
   input logic              reset,
   id_ex_issue_reg_if.slave bus
);
   import id_ex_issue_reg_pkg::*;

   ID_EX_PACKET     w_inPacket [WAYS];
   ID_EX_PACKET     r_exPacket [WAYS];
   logic [1:0]      w_keep;
   logic [WAYS-1:0] w_kept;
   logic            w_rollbackAny;
   logic            w_redirectValid;
   logic [XLEN-1:0] w_redirectPc;
   logic [2:0]      r_rbStreak;

   // Gather the separate way ports into an array so the per-way logic is uniform.
   always_comb begin
      w_inPacket[0] = bus.id_packet_in_0;
      w_inPacket[1] = bus.id_packet_in_1;
      w_inPacket[2] = bus.id_packet_in_2;
   end

   // Ways below `keep` survive; the rest are the rolled-back youngest ways.
   assign w_keep        = 2'd3 - bus.rollback;
   assign w_kept        = {w_keep > 2'd2, w_keep > 2'd1, w_keep > 2'd0};
   assign w_rollbackAny = (bus.rollback != 2'd0);

   // Redirect only when the rollback is actually accepted this cycle; reset
   // also suppresses it so fetch never sees a restart while we are clearing.
   assign w_redirectValid = w_rollbackAny & bus.enable & ~bus.squash & ~reset;

   // The oldest squashed way is index `keep`; its PC is where fetch restarts.
   always_comb begin
      w_redirectPc = '0;
      if (w_redirectValid) begin
         case (w_keep)
            2'd0:    w_redirectPc = w_inPacket[0].PC;
            2'd1:    w_redirectPc = w_inPacket[1].PC;
            2'd2:    w_redirectPc = w_inPacket[2].PC;
            default: w_redirectPc = '0;
         endcase
      end
   end

   // Pipeline register and rollback streak. Squash beats a stall, and a stall
   // freezes everything, streak included.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WAYS; i++) r_exPacket[i] <= BUBBLE;
         r_rbStreak <= '0;
      end else if (bus.squash) begin
         for (int i = 0; i < WAYS; i++) r_exPacket[i] <= BUBBLE;
         r_rbStreak <= '0;
      end else if (bus.enable) begin
         for (int i = 0; i < WAYS; i++) r_exPacket[i] <= w_kept[i] ? w_inPacket[i] : BUBBLE;
         if (w_rollbackAny) begin
            r_rbStreak <= (r_rbStreak >= RB_SAT_MAX) ? r_rbStreak : r_rbStreak + 3'd1;
         end else begin
            r_rbStreak <= '0;
         end
      end
   end

`ifdef ROLLBACK_STATS_EN
   logic [1:0]  w_squashedValid;
   logic [31:0] r_statRbCycles;
   logic [31:0] r_statRbInsts;

   // Count valid instructions thrown away by this cycle's rollback.
   assign w_squashedValid = 2'(~w_kept[0] & w_inPacket[0].valid)
                          + 2'(~w_kept[1] & w_inPacket[1].valid)
                          + 2'(~w_kept[2] & w_inPacket[2].valid);

   // Statistics only advance on an accepted rollback; both wrap naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_statRbCycles <= '0;
         r_statRbInsts  <= '0;
      end else if (!bus.squash && bus.enable && w_rollbackAny) begin
         r_statRbCycles <= r_statRbCycles + 32'd1;
         r_statRbInsts  <= r_statRbInsts + {30'd0, w_squashedValid};
      end
   end

   assign bus.stat_rb_cycles = r_statRbCycles;
   assign bus.stat_rb_insts  = r_statRbInsts;
`endif

   assign bus.ex_packet_0    = r_exPacket[0];
   assign bus.ex_packet_1    = r_exPacket[1];
   assign bus.ex_packet_2    = r_exPacket[2];
   assign bus.redirect_valid = w_redirectValid;
   assign bus.redirect_pc    = w_redirectPc;
   assign bus.rb_streak      = r_rbStreak;

endmodule
